// File: rtl/decoder_38.sv
// Registered 3-to-8 line decoder with enable and output-valid flag.
// Optional saturating 16-bit hit counter enabled by defining DECODER38_HIT_CNT_EN.
module decoder_38 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] in,
  output logic [7:0] out,
  output logic       out_vld
`ifdef DECODER38_HIT_CNT_EN
  ,
  output logic [15:0] hit_cnt
`endif
);

  // One-cold polarity is an XOR against this mask, which is also the idle value.
  localparam logic [7:0] IDLE_MASK = ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [7:0] one_hot(input logic [2:0] sel);
    logic [7:0] v;
    v = 8'h00;
    v[sel] = 1'b1;
    return v;
  endfunction

  logic [7:0] out_nxt_s;
  logic [7:0] out_r;
  logic       vld_r;

  // Next decode value, already in the configured polarity.
  always_comb begin
    out_nxt_s = IDLE_MASK;
    if (en) begin
      out_nxt_s = one_hot(in) ^ IDLE_MASK;
    end else begin
      out_nxt_s = IDLE_MASK;
    end
  end

  // Output and valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r <= IDLE_MASK;
      vld_r <= 1'b0;
    end else begin
      out_r <= out_nxt_s;
      vld_r <= en;
    end
  end

  assign out     = out_r;
  assign out_vld = vld_r;

`ifdef DECODER38_HIT_CNT_EN
  logic [15:0] hit_cnt_r;

  // Saturating count of enabled decode cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r <= 16'h0000;
    end else if (en && (hit_cnt_r != 16'hFFFF)) begin
      hit_cnt_r <= hit_cnt_r + 16'h0001;
    end else begin
      hit_cnt_r <= hit_cnt_r;
    end
  end

  assign hit_cnt = hit_cnt_r;
`endif

endmodule

// File: tb/tb_decoder_38.sv
// Scoreboard bench for decoder_38: one active-high and one active-low instance
// share stimulus; a negedge monitor pops expected values and compares.
module tb_decoder_38;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] in;
  logic [7:0] out_h;
  logic       vld_h;
  logic [7:0] out_l;
  logic       vld_l;
`ifdef DECODER38_HIT_CNT_EN
  logic [15:0] cnt_h;
  logic [15:0] cnt_l;
`endif

  int checks;
  int fails;

  logic [7:0]  q_h[$];
  logic [7:0]  q_l[$];
  logic        q_v[$];
  logic [15:0] q_c[$];
  string       q_n[$];

  logic [15:0] exp_cnt;

  logic [7:0] hot  [8];
  logic [7:0] cold [8];

  decoder_38 #(.ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(out_h), .out_vld(vld_h)
`ifdef DECODER38_HIT_CNT_EN
    , .hit_cnt(cnt_h)
`endif
  );

  decoder_38 #(.ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .en(en), .in(in), .out(out_l), .out_vld(vld_l)
`ifdef DECODER38_HIT_CNT_EN
    , .hit_cnt(cnt_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus; optionally queue the expected response.
  task automatic step(input logic r, input logic e, input logic [2:0] s,
                      input logic [7:0] eh, input logic [7:0] el,
                      input logic push, input string nm);
    @(negedge clk);
    #1;
    rst = r;
    en  = e;
    in  = s;
    if (r) exp_cnt = 16'h0000;
    else if (e && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
    if (push) begin
      q_h.push_back(eh);
      q_l.push_back(el);
      q_v.push_back(r ? 1'b0 : e);
      q_c.push_back(exp_cnt);
      q_n.push_back(nm);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry.
  always @(negedge clk) begin
    if (q_h.size() > 0) begin
      logic [7:0]  eh;
      logic [7:0]  el;
      logic        ev;
      logic [15:0] ec;
      string       nm;
      eh = q_h.pop_front();
      el = q_l.pop_front();
      ev = q_v.pop_front();
      ec = q_c.pop_front();
      nm = q_n.pop_front();
      checks = checks + 1;
      if (out_h !== eh) begin
        fails = fails + 1;
        $display("FAIL %s out: got %h expected %h", nm, out_h, eh);
      end
      checks = checks + 1;
      if (out_l !== el) begin
        fails = fails + 1;
        $display("FAIL %s out_active_low: got %h expected %h", nm, out_l, el);
      end
      checks = checks + 1;
      if (vld_h !== ev || vld_l !== ev) begin
        fails = fails + 1;
        $display("FAIL %s out_vld: got %b/%b expected %b", nm, vld_h, vld_l, ev);
      end
`ifdef DECODER38_HIT_CNT_EN
      checks = checks + 1;
      if (cnt_h !== ec || cnt_l !== ec) begin
        fails = fails + 1;
        $display("FAIL %s hit_cnt: got %h/%h expected %h", nm, cnt_h, cnt_l, ec);
      end
`endif
    end
  end

  initial begin
    checks  = 0;
    fails   = 0;
    exp_cnt = 16'h0000;
    rst = 1'b1;
    en  = 1'b0;
    in  = 3'd0;
    hot  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    cold = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    step(1'b1, 1'b1, 3'd5, 8'h00, 8'hFF, 1'b1, "reset0");
    step(1'b1, 1'b1, 3'd5, 8'h00, 8'hFF, 1'b1, "reset1");

    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 3'(i), 8'h00, 8'hFF, 1'b1, "disabled_sweep");

    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 3'(i), hot[i], cold[i], 1'b1, "enabled_sweep");

    step(1'b0, 1'b1, 3'd3, 8'h08, 8'hF7, 1'b1, "toggle_on");
    step(1'b0, 1'b0, 3'd3, 8'h00, 8'hFF, 1'b1, "toggle_off");
    step(1'b0, 1'b1, 3'd6, 8'h40, 8'hBF, 1'b1, "toggle_on2");
    step(1'b1, 1'b1, 3'd7, 8'h00, 8'hFF, 1'b1, "midstream_reset");
    step(1'b0, 1'b1, 3'd0, 8'h01, 8'hFE, 1'b1, "first_after_reset");
    step(1'b0, 1'b0, 3'd7, 8'h00, 8'hFF, 1'b1, "disable_after_reset");

`ifdef DECODER38_HIT_CNT_EN
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, "cnt_reset");
    for (int k = 0; k < 21; k++) begin
      if (k % 4 == 2)
        step(1'b0, 1'b0, 3'(k), 8'h00, 8'hFF, 1'b1, "cnt_interleave_off");
      else
        step(1'b0, 1'b1, 3'(k), hot[k % 8], cold[k % 8], 1'b1, "cnt_interleave_on");
    end
    step(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, "cnt_sixteen");
    if (exp_cnt != 16'd16) $display("bench model count drifted: %0d", exp_cnt);
    for (int k = 0; k < 70000; k++)
      step(1'b0, 1'b1, 3'd2, 8'h04, 8'hFB, 1'b0, "");
    step(1'b0, 1'b1, 3'd4, 8'h10, 8'hEF, 1'b1, "cnt_saturated");
    step(1'b0, 1'b0, 3'd4, 8'h00, 8'hFF, 1'b1, "cnt_hold");
`endif

    for (int w = 0; w < 10 && q_h.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #2;
    checks = checks + 1;
    if (q_h.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: got %0d pending expected 0", q_h.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
